// File: rtl/loop_chk_pkg.sv
// Shared types and constants for the arithmetic-loop trace checker.
package loop_chk_pkg;

  localparam int DEF_WIDTH      = 10;
  localparam int DEF_CYC_W      = 16;
  localparam int DEF_MAX_CYCLES = 1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_INVARIANT   = 3'd1;
  localparam logic [2:0] ERR_I_MISMATCH  = 3'd2;
  localparam logic [2:0] ERR_SN_MISMATCH = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT     = 3'd4;
  localparam logic [2:0] ERR_BAD_CONFIG  = 3'd5;

  // Status flags {busy, done, pass, fail} that belong to a given state.
  function automatic logic [3:0] state_flags(state_t s);
    logic [3:0] f;
    f = 4'b0000;
    case (s)
      RUN:     f = 4'b1000;
      PASS:    f = 4'b0110;
      FAIL:    f = 4'b0101;
      default: f = 4'b0000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/loop_trace_checker_if.sv
// Bundle between the loop stimulus side (master) and the trace checker (slave).
//
// Control protocol: start and clear are single-cycle pulses sampled on the
// rising clock edge; there is no ready/backpressure. start is only acted on
// in IDLE (n is sampled with it), clear only in PASS/FAIL. If both are high
// together, start wins in IDLE and clear wins in PASS/FAIL. selector, i and
// sn are sampled every edge while the checker is running.
interface loop_trace_checker_if #(
  parameter int WIDTH = loop_chk_pkg::DEF_WIDTH,
  parameter int CYC_W = loop_chk_pkg::DEF_CYC_W
);
  logic             start;
  logic             clear;
  logic [WIDTH-1:0] n;
  logic             selector;
  logic [WIDTH-1:0] i;
  logic [WIDTH-1:0] sn;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [2:0]       err_code;
  logic [CYC_W-1:0] err_cycle;
  logic [CYC_W-1:0] cycle_cnt;

  modport master (
    output start, clear, n, selector, i, sn,
    input  busy, done, pass, fail, err_code, err_cycle, cycle_cnt
  );

  modport slave (
    input  start, clear, n, selector, i, sn,
    output busy, done, pass, fail, err_code, err_cycle, cycle_cnt
  );
endinterface

// File: rtl/loop_shadow_model.sv
// Golden model of the counting loop: i starts at 1, sn at 0, and both step
// together when selector is high, stopping once i has passed the bound.
module loop_shadow_model
  import loop_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             step_en,
  input  logic             selector,
  input  logic [WIDTH-1:0] n_q,
  output logic [WIDTH-1:0] exp_i,
  output logic [WIDTH-1:0] exp_sn
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Shadow loop state; the exp_i <= n_q guard stops the count at n+1 so it never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_i  <= ONE;
      exp_sn <= '0;
    end else if (init) begin
      exp_i  <= ONE;
      exp_sn <= '0;
    end else if (step_en && selector && (exp_i <= n_q)) begin
      exp_i  <= exp_i + ONE;
      exp_sn <= exp_sn + ONE;
    end
  end

endmodule

// File: rtl/loop_trace_checker.sv
// Observer for the arithmetic-loop DUT: follows i/sn against a shadow model,
// checks the sn == i-1 invariant and the exit condition, and reports a
// pass/fail verdict with an error code and the cycle of the first failure.
module loop_trace_checker
  import loop_chk_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CYC_W      = DEF_CYC_W,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  loop_trace_checker_if.slave   bus,
  output state_t                dbg_state
);

  localparam logic [WIDTH-1:0] W_ONE    = WIDTH'(1);
  localparam logic [CYC_W-1:0] C_ONE    = CYC_W'(1);
  localparam logic [CYC_W-1:0] C_LAST   = CYC_W'(MAX_CYCLES - 1);

  state_t           state;
  logic [WIDTH-1:0] n_q;
  logic [CYC_W-1:0] cycle_cnt;
  logic [CYC_W-1:0] err_cycle;
  logic [2:0]       err_code;
  logic [3:0]       flags_q;

  logic [WIDTH-1:0] exp_i;
  logic [WIDTH-1:0] exp_sn;
  logic [WIDTH-1:0] i_minus1;
  logic [WIDTH-1:0] n_plus1;
  logic [2:0]       cmp_code;
  logic             exit_hit;
  logic             timeout_hit;
  logic             n_bad;
  logic             shadow_init;
  logic             shadow_step;

  // Per-edge comparisons of the sampled DUT values against the pre-edge shadow.
  always_comb begin
    i_minus1    = bus.i - W_ONE;
    n_plus1     = n_q + W_ONE;
    cmp_code    = ERR_NONE;
    if (bus.sn != i_minus1) begin
      cmp_code = ERR_INVARIANT;
    end else if (bus.i != exp_i) begin
      cmp_code = ERR_I_MISMATCH;
    end else if (bus.sn != exp_sn) begin
      cmp_code = ERR_SN_MISMATCH;
    end
    exit_hit    = (bus.i == n_plus1) && (bus.sn == n_q);
    timeout_hit = (cycle_cnt == C_LAST);
    // n must leave room for n+1 in WIDTH bits.
    n_bad       = (bus.n == '1);
    shadow_init = (state == IDLE) && bus.start && !n_bad;
    shadow_step = (state == RUN) && (cmp_code == ERR_NONE) && !exit_hit && !timeout_hit;
  end

  loop_shadow_model #(.WIDTH(WIDTH)) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .init     (shadow_init),
    .step_en  (shadow_step),
    .selector (bus.selector),
    .n_q      (n_q),
    .exp_i    (exp_i),
    .exp_sn   (exp_sn)
  );

  // Checker FSM with registered status flags, error capture and cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      n_q       <= '0;
      cycle_cnt <= '0;
      err_cycle <= '0;
      err_code  <= ERR_NONE;
      flags_q   <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (n_bad) begin
              state     <= FAIL;
              flags_q   <= state_flags(FAIL);
              err_code  <= ERR_BAD_CONFIG;
              err_cycle <= '0;
            end else begin
              state     <= RUN;
              flags_q   <= state_flags(RUN);
              n_q       <= bus.n;
              cycle_cnt <= '0;
            end
          end
        end
        RUN: begin
          cycle_cnt <= cycle_cnt + C_ONE;
          if (cmp_code != ERR_NONE) begin
            state     <= FAIL;
            flags_q   <= state_flags(FAIL);
            err_code  <= cmp_code;
            err_cycle <= cycle_cnt;
          end else if (exit_hit) begin
            state   <= PASS;
            flags_q <= state_flags(PASS);
          end else if (timeout_hit) begin
            state     <= FAIL;
            flags_q   <= state_flags(FAIL);
            err_code  <= ERR_TIMEOUT;
            err_cycle <= cycle_cnt;
          end
        end
        PASS, FAIL: begin
          if (bus.clear) begin
            state     <= IDLE;
            flags_q   <= state_flags(IDLE);
            err_code  <= ERR_NONE;
            err_cycle <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          flags_q <= state_flags(IDLE);
        end
      endcase
    end
  end

  assign bus.busy      = flags_q[3];
  assign bus.done      = flags_q[2];
  assign bus.pass      = flags_q[1];
  assign bus.fail      = flags_q[0];
  assign bus.err_code  = err_code;
  assign bus.err_cycle = err_cycle;
  assign bus.cycle_cnt = cycle_cnt;
  assign dbg_state     = state;

endmodule
